csr_timer_file: RTL and testbench



---
 rtl/csr_timer_file.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_csr_timer_file.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_timer_file.sv
// csr_timer_file: control/status register file beside the writeback stage.
// It holds the exception CSRs (CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY),
// the SAVE scratch registers, TID, a 64-bit stable counter and a countdown
// timer (TCFG/TVAL/TICLR) that raises ESTAT.IS[11].
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   csr_re, csr_num, csr_rvalue combinational read port (0 when csr_re low)
//   csr_we, csr_wmask,
//   csr_wvalue                  masked write port
//   hw_int_in, ipi_int_in       interrupt levels, sampled into ESTAT.IS
//   wb_ex, wb_ecode,
//   wb_esubcode, wb_pc,
//   wb_badv_we, wb_vaddr        exception commit from writeback
//   ertn_flush                  ERTN commit
//   ex_entry, era               exception entry and return addresses
//   has_int                     pending enabled interrupt
//   cnt_value                   stable counter
module csr_timer_file #(
    parameter int          TIMER_W      = 32,
    parameter int          SAVE_N       = 4,
    parameter logic [31:0] TID_RESET    = 32'h0,
    parameter logic [31:0] EENTRY_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic        wb_badv_we,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    output logic [31:0] ex_entry,
    output logic [31:0] era,
    output logic        has_int,
    output logic [63:0] cnt_value
);

    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_BADV   = 14'h07;
    localparam logic [13:0] CSR_EENTRY = 14'h0C;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;

    // LIE bit 10 has no interrupt source behind it
    localparam logic [12:0]        LIE_MASK = 13'h1BFF;
    localparam logic [TIMER_W-1:0] TV_ONE   = {{(TIMER_W-1){1'b0}}, 1'b1};

    typedef enum logic {T_IDLE, T_RUN} tstate_e;

    function automatic logic [31:0] merge32(input logic [31:0] old,
                                            input logic [31:0] m,
                                            input logic [31:0] v);
        return (m & v) | (~m & old);
    endfunction

    // architectural state
    logic [1:0]               plv_q,   plv_d;
    logic                     ie_q,    ie_d;
    logic [1:0]               pplv_q,  pplv_d;
    logic                     pie_q,   pie_d;
    logic [12:0]              lie_q,   lie_d;
    logic [1:0]               sw_q,    sw_d;
    logic [7:0]               hw_q;
    logic                     ipi_q;
    logic [5:0]               ecode_q, ecode_d;
    logic [8:0]               esub_q,  esub_d;
    logic [31:0]              era_q,   era_d;
    logic [31:0]              badv_q,  badv_d;
    logic [25:0]              eentry_q, eentry_d;
    logic [31:0]              tid_q,   tid_d;
    logic [SAVE_N-1:0][31:0]  save_q,  save_d;
    logic [63:0]              cnt_q;

    // timer state (owned by the FSM block)
    tstate_e                  tstate_q;
    logic [TIMER_W-1:0]       tcfg_q;
    logic [TIMER_W-1:0]       tval_q;
    logic                     is_timer_q;

    // write strobes
    logic we_crmd, we_prmd, we_ecfg, we_estat, we_era, we_badv;
    logic we_eentry, we_tid, we_tcfg, ticlr_clr;
    assign we_crmd   = csr_we && (csr_num == CSR_CRMD);
    assign we_prmd   = csr_we && (csr_num == CSR_PRMD);
    assign we_ecfg   = csr_we && (csr_num == CSR_ECFG);
    assign we_estat  = csr_we && (csr_num == CSR_ESTAT);
    assign we_era    = csr_we && (csr_num == CSR_ERA);
    assign we_badv   = csr_we && (csr_num == CSR_BADV);
    assign we_eentry = csr_we && (csr_num == CSR_EENTRY);
    assign we_tid    = csr_we && (csr_num == CSR_TID);
    assign we_tcfg   = csr_we && (csr_num == CSR_TCFG);
    assign ticlr_clr = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];

    // TCFG value as it will be after a write this cycle
    logic [TIMER_W-1:0] tcfg_w;
    assign tcfg_w = (csr_wmask[TIMER_W-1:0] & csr_wvalue[TIMER_W-1:0]) |
                    (~csr_wmask[TIMER_W-1:0] & tcfg_q);

    logic timer_fire;
    assign timer_fire = (tstate_q == T_RUN) && (tval_q == '0);

    // next-state for the non-timer registers
    always_comb begin
        plv_d    = plv_q;
        ie_d     = ie_q;
        pplv_d   = pplv_q;
        pie_d    = pie_q;
        lie_d    = lie_q;
        sw_d     = sw_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        tid_d    = tid_q;
        save_d   = save_q;

        if (wb_ex) begin
            plv_d = 2'd0;
            ie_d  = 1'b0;
        end else if (ertn_flush) begin
            plv_d = pplv_q;
            ie_d  = pie_q;
        end else if (we_crmd) begin
            {ie_d, plv_d} = (csr_wmask[2:0] & csr_wvalue[2:0]) |
                            (~csr_wmask[2:0] & {ie_q, plv_q});
        end

        if (wb_ex) begin
            pplv_d = plv_q;
            pie_d  = ie_q;
        end else if (we_prmd) begin
            {pie_d, pplv_d} = (csr_wmask[2:0] & csr_wvalue[2:0]) |
                              (~csr_wmask[2:0] & {pie_q, pplv_q});
        end

        if (wb_ex) begin
            ecode_d = wb_ecode;
            esub_d  = wb_esubcode;
            era_d   = wb_pc;
        end else if (we_era) begin
            era_d = merge32(era_q, csr_wmask, csr_wvalue);
        end

        if (wb_ex && wb_badv_we)
            badv_d = wb_vaddr;
        else if (we_badv)
            badv_d = merge32(badv_q, csr_wmask, csr_wvalue);

        if (we_ecfg)
            lie_d = ((csr_wmask[12:0] & csr_wvalue[12:0]) | (~csr_wmask[12:0] & lie_q)) & LIE_MASK;
        if (we_estat)
            sw_d = (csr_wmask[1:0] & csr_wvalue[1:0]) | (~csr_wmask[1:0] & sw_q);
        if (we_eentry)
            eentry_d = (csr_wmask[31:6] & csr_wvalue[31:6]) | (~csr_wmask[31:6] & eentry_q);
        if (we_tid)
            tid_d = merge32(tid_q, csr_wmask, csr_wvalue);

        for (int i = 0; i < SAVE_N; i++) begin
            if (csr_we && (csr_num == CSR_SAVE0 + 14'(i)))
                save_d[i] = merge32(save_q[i], csr_wmask, csr_wvalue);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plv_q    <= 2'd0;
            ie_q     <= 1'b0;
            pplv_q   <= 2'd0;
            pie_q    <= 1'b0;
            lie_q    <= '0;
            sw_q     <= '0;
            hw_q     <= '0;
            ipi_q    <= 1'b0;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            badv_q   <= '0;
            eentry_q <= EENTRY_RESET[31:6];
            tid_q    <= TID_RESET;
            save_q   <= '0;
            cnt_q    <= '0;
        end else begin
            plv_q    <= plv_d;
            ie_q     <= ie_d;
            pplv_q   <= pplv_d;
            pie_q    <= pie_d;
            lie_q    <= lie_d;
            sw_q     <= sw_d;
            hw_q     <= hw_int_in;
            ipi_q    <= ipi_int_in;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            tid_q    <= tid_d;
            save_q   <= save_d;
            cnt_q    <= cnt_q + 64'd1;
        end
    end

    // Timer FSM. A TCFG write overrides the countdown in the same cycle;
    // a fire in the same cycle as a TICLR keeps IS[11] set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tstate_q   <= T_IDLE;
            tcfg_q     <= '0;
            tval_q     <= '0;
            is_timer_q <= 1'b0;
        end else begin
            if (timer_fire)
                is_timer_q <= 1'b1;
            else if (ticlr_clr)
                is_timer_q <= 1'b0;

            if (we_tcfg) begin
                tcfg_q <= tcfg_w;
                if (tcfg_w[0]) begin
                    tval_q   <= {tcfg_w[TIMER_W-1:2], 2'b00};
                    tstate_q <= T_RUN;
                end else begin
                    tstate_q <= T_IDLE;
                end
            end else if (tstate_q == T_RUN) begin
                if (tval_q != '0) begin
                    tval_q <= tval_q - TV_ONE;
                end else if (tcfg_q[1]) begin
                    tval_q <= {tcfg_q[TIMER_W-1:2], 2'b00};
                end else begin
                    tval_q    <= '1;
                    tcfg_q[0] <= 1'b0;
                    tstate_q  <= T_IDLE;
                end
            end
        end
    end

    // read side
    logic [12:0] is_vec;
    logic [31:0] tcfg_ext, tval_ext, rd;
    assign is_vec = {ipi_q, is_timer_q, 1'b0, hw_q, sw_q};

    always_comb begin
        tcfg_ext = '0;
        tval_ext = '0;
        tcfg_ext[TIMER_W-1:0] = tcfg_q;
        tval_ext[TIMER_W-1:0] = tval_q;
    end

    always_comb begin
        rd = '0;
        case (csr_num)
            CSR_CRMD:   rd = {28'd0, 1'b1, ie_q, plv_q};
            CSR_PRMD:   rd = {29'd0, pie_q, pplv_q};
            CSR_ECFG:   rd = {19'd0, lie_q};
            CSR_ESTAT:  rd = {1'b0, esub_q, ecode_q, 3'd0, is_vec};
            CSR_ERA:    rd = era_q;
            CSR_BADV:   rd = badv_q;
            CSR_EENTRY: rd = {eentry_q, 6'd0};
            CSR_TID:    rd = tid_q;
            CSR_TCFG:   rd = tcfg_ext;
            CSR_TVAL:   rd = tval_ext;
            default:    rd = '0;
        endcase
        for (int i = 0; i < SAVE_N; i++) begin
            if (csr_num == CSR_SAVE0 + 14'(i))
                rd = save_q[i];
        end
    end

    assign csr_rvalue = csr_re ? rd : 32'd0;
    assign ex_entry   = {eentry_q, 6'd0};
    assign era        = era_q;
    assign has_int    = (|(is_vec & lie_q)) & ie_q;
    assign cnt_value  = cnt_q;

endmodule

// File: tb/tb_csr_timer_file.sv
// Directed bench for csr_timer_file: reset state, masked writes, one-shot and
// periodic timer, TICLR/fire race, exception entry/return, SAVE range,
// interrupt sampling, stable counter and reset mid-count.
module tb_csr_timer_file;

    localparam logic [31:0] TIDR = 32'hA5A5_0001;
    localparam logic [31:0] EER  = 32'h1C00_807F;

    localparam logic [13:0] A_CRMD   = 14'h00;
    localparam logic [13:0] A_PRMD   = 14'h01;
    localparam logic [13:0] A_ECFG   = 14'h04;
    localparam logic [13:0] A_ESTAT  = 14'h05;
    localparam logic [13:0] A_ERA    = 14'h06;
    localparam logic [13:0] A_BADV   = 14'h07;
    localparam logic [13:0] A_EENTRY = 14'h0C;
    localparam logic [13:0] A_SAVE0  = 14'h30;
    localparam logic [13:0] A_SAVE3  = 14'h33;
    localparam logic [13:0] A_SAVE4  = 14'h34;
    localparam logic [13:0] A_TID    = 14'h40;
    localparam logic [13:0] A_TCFG   = 14'h41;
    localparam logic [13:0] A_TVAL   = 14'h42;
    localparam logic [13:0] A_TICLR  = 14'h44;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        csr_re = 1'b0;
    logic [13:0] csr_num = '0;
    logic [31:0] csr_rvalue;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wmask = '0;
    logic [31:0] csr_wvalue = '0;
    logic [7:0]  hw_int_in = '0;
    logic        ipi_int_in = 1'b0;
    logic        wb_ex = 1'b0;
    logic [5:0]  wb_ecode = '0;
    logic [8:0]  wb_esubcode = '0;
    logic [31:0] wb_pc = '0;
    logic        wb_badv_we = 1'b0;
    logic [31:0] wb_vaddr = '0;
    logic        ertn_flush = 1'b0;
    logic [31:0] ex_entry;
    logic [31:0] era;
    logic        has_int;
    logic [63:0] cnt_value;

    int checks = 0;
    int errors = 0;
    logic [63:0] model_cnt;

    csr_timer_file #(
        .TIMER_W(32), .SAVE_N(4), .TID_RESET(TIDR), .EENTRY_RESET(EER)
    ) dut (
        .clk(clk), .resetn(resetn),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_badv_we(wb_badv_we), .wb_vaddr(wb_vaddr),
        .ertn_flush(ertn_flush), .ex_entry(ex_entry), .era(era),
        .has_int(has_int), .cnt_value(cnt_value)
    );

    always #50 clk = ~clk;

    // reference stable counter
    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_cnt <= 64'd0;
        else         model_cnt <= model_cnt + 64'd1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // one write, committed at the next rising edge
    task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
        csr_we = 1'b1; csr_num = a; csr_wmask = m; csr_wvalue = v;
        @(negedge clk);
        csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    endtask

    task automatic rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
        csr_re = 1'b1; csr_num = a;
        #1;
        chk(tag, {32'd0, csr_rvalue}, {32'd0, exp});
        csr_re = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_cnt", cnt_value, 64'd0);
        chk("rst_has_int", {63'd0, has_int}, 64'd0);
        chk("rst_era", {32'd0, era}, 64'd0);
        chk("rst_ex_entry", {32'd0, ex_entry}, 64'h1C00_8040);
        csr_re = 1'b0; csr_num = A_CRMD; #1;
        chk("re_low", {32'd0, csr_rvalue}, 64'd0);
        rd("rst_crmd", A_CRMD, 32'h8);
        rd("rst_prmd", A_PRMD, 32'h0);
        rd("rst_ecfg", A_ECFG, 32'h0);
        rd("rst_estat", A_ESTAT, 32'h0);
        rd("rst_era_csr", A_ERA, 32'h0);
        rd("rst_badv", A_BADV, 32'h0);
        rd("rst_eentry", A_EENTRY, 32'h1C00_8040);
        rd("rst_save0", A_SAVE0, 32'h0);
        rd("rst_save3", A_SAVE3, 32'h0);
        rd("rst_tid", A_TID, TIDR);
        rd("rst_tcfg", A_TCFG, 32'h0);
        rd("rst_tval", A_TVAL, 32'h0);
        rd("rst_ticlr", A_TICLR, 32'h0);
        resetn = 1'b1;
        tick();
        chk("cnt_first", cnt_value, model_cnt);

        // ---------------- simple register behaviour ----------------
        wr(A_ECFG, 32'hFFFF_FFFF, 32'h1FFF);
        rd("ecfg_lie10", A_ECFG, 32'h1BFF);
        wr(A_ECFG, 32'hFFFF_FFFF, 32'h0);
        wr(A_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("estat_sw_only", A_ESTAT, 32'h3);
        wr(A_ESTAT, 32'hFFFF_FFFF, 32'h0);
        rd("estat_sw_clr", A_ESTAT, 32'h0);
        wr(A_EENTRY, 32'hFFFF_FFFF, 32'h1234_5678);
        rd("eentry_wr", A_EENTRY, 32'h1234_5640);
        chk("ex_entry_wr", {32'd0, ex_entry}, 64'h1234_5640);
        wr(A_TID, 32'hFFFF_FFFF, 32'h0BAD_F00D);
        rd("tid_wr", A_TID, 32'h0BAD_F00D);
        rd("unmapped", 14'h43, 32'h0);

        // ---------------- one-shot timer ----------------
        wr(A_TCFG, 32'hFFFF_FFFF, 32'h11);
        rd("os_tval_load", A_TVAL, 32'd16);
        rd("os_tcfg", A_TCFG, 32'h11);
        repeat (15) tick();
        rd("os_tval_1", A_TVAL, 32'd1);
        tick();
        rd("os_tval_0", A_TVAL, 32'd0);
        rd("os_no_fire_yet", A_ESTAT, 32'h0);
        tick();
        rd("os_fire", A_ESTAT, 32'h800);
        rd("os_tval_ones", A_TVAL, 32'hFFFF_FFFF);
        rd("os_en_clr", A_TCFG, 32'h10);
        tick();
        rd("os_idle_hold", A_TVAL, 32'hFFFF_FFFF);
        wr(A_TICLR, 32'h1, 32'h1);
        rd("os_ticlr", A_ESTAT, 32'h0);

        // ---------------- periodic timer ----------------
        wr(A_ECFG, 32'hFFFF_FFFF, 32'h800);
        wr(A_CRMD, 32'h4, 32'h4);
        rd("crmd_ie", A_CRMD, 32'hC);
        wr(A_TCFG, 32'hFFFF_FFFF, 32'h7);
        rd("per_load", A_TVAL, 32'd4);
        repeat (4) tick();
        rd("per_tval0", A_TVAL, 32'd0);
        chk("per_no_int", {63'd0, has_int}, 64'd0);
        tick();
        rd("per_fire1", A_ESTAT, 32'h800);
        chk("per_has_int", {63'd0, has_int}, 64'd1);
        rd("per_reload", A_TVAL, 32'd4);
        wr(A_TICLR, 32'h1, 32'h1);
        rd("per_clr", A_ESTAT, 32'h0);
        chk("per_clr_int", {63'd0, has_int}, 64'd0);
        rd("per_tval3", A_TVAL, 32'd3);
        repeat (3) tick();
        rd("per_tval0b", A_TVAL, 32'd0);
        wr(A_TICLR, 32'h1, 32'h1);           // lands on the fire edge
        rd("ticlr_race", A_ESTAT, 32'h800);
        rd("per_reload2", A_TVAL, 32'd4);
        chk("race_has_int", {63'd0, has_int}, 64'd1);
        wr(A_TCFG, 32'hFFFF_FFFF, 32'h6);    // En=0 stops, TVAL holds
        rd("stop_tval", A_TVAL, 32'd4);
        rd("stop_tcfg", A_TCFG, 32'h6);
        tick();
        rd("stop_hold", A_TVAL, 32'd4);
        wr(A_TICLR, 32'h1, 32'h1);
        rd("stop_clr", A_ESTAT, 32'h0);

        // ---------------- exception entry / return ----------------
        wr(A_CRMD, 32'hFFFF_FFFF, 32'h7);
        rd("crmd_pre_ex", A_CRMD, 32'hF);
        wb_ex = 1'b1; wb_ecode = 6'h9; wb_esubcode = 9'h5;
        wb_pc = 32'h1C00_0100; wb_badv_we = 1'b1; wb_vaddr = 32'h1234_5671;
        tick();
        wb_ex = 1'b0; wb_badv_we = 1'b0;
        rd("ex_crmd", A_CRMD, 32'h8);
        rd("ex_prmd", A_PRMD, 32'h7);
        rd("ex_era", A_ERA, 32'h1C00_0100);
        rd("ex_badv", A_BADV, 32'h1234_5671);
        rd("ex_estat", A_ESTAT, 32'h0149_0000);
        chk("ex_era_port", {32'd0, era}, 64'h1C00_0100);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        rd("ertn_crmd", A_CRMD, 32'hF);
        wb_ex = 1'b1; wb_pc = 32'h1C00_0200;
        tick();
        wb_ex = 1'b0;
        rd("ex2_badv_kept", A_BADV, 32'h1234_5671);
        rd("ex2_era", A_ERA, 32'h1C00_0200);

        // ---------------- masked write and SAVE range ----------------
        wr(A_CRMD, 32'hFFFF_FFFF, 32'h0);
        wr(A_CRMD, 32'h3, 32'h7);
        rd("crmd_masked", A_CRMD, 32'hB);
        wr(A_SAVE3, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        rd("save_last", A_SAVE3, 32'hDEAD_BEEF);
        wr(A_SAVE4, 32'hFFFF_FFFF, 32'hCAFE_F00D);
        rd("save_beyond", A_SAVE4, 32'h0);
        rd("save0_untouched", A_SAVE0, 32'h0);
        wr(A_SAVE0, 32'h0000_FFFF, 32'h1234_5678);
        rd("save0_masked", A_SAVE0, 32'h0000_5678);

        // ---------------- interrupt sampling ----------------
        wr(A_ECFG, 32'hFFFF_FFFF, 32'h200);
        wr(A_CRMD, 32'h4, 32'h4);
        hw_int_in = 8'h80;
        #1;
        chk("hw_not_yet", {63'd0, has_int}, 64'd0);
        tick();
        chk("hw_has_int", {63'd0, has_int}, 64'd1);
        rd("hw_estat", A_ESTAT, 32'h0149_0200);
        hw_int_in = 8'h00;
        tick();
        chk("hw_drop", {63'd0, has_int}, 64'd0);
        ipi_int_in = 1'b1;
        tick();
        rd("ipi_estat", A_ESTAT, 32'h0149_1000);
        chk("ipi_masked", {63'd0, has_int}, 64'd0);
        ipi_int_in = 1'b0;
        tick();

        // ---------------- stable counter ----------------
        chk("cnt_a", cnt_value, model_cnt);
        tick();
        chk("cnt_b", cnt_value, model_cnt);
        repeat (7) tick();
        chk("cnt_c", cnt_value, model_cnt);

        // ---------------- reset mid-count ----------------
        wr(A_TCFG, 32'hFFFF_FFFF, 32'h11);
        repeat (3) tick();
        resetn = 1'b0;
        #1;
        rd("midrst_tval", A_TVAL, 32'h0);
        rd("midrst_tcfg", A_TCFG, 32'h0);
        rd("midrst_estat", A_ESTAT, 32'h0);
        rd("midrst_crmd", A_CRMD, 32'h8);
        chk("midrst_cnt", cnt_value, 64'd0);
        tick();
        resetn = 1'b1;
        repeat (25) tick();
        rd("midrst_no_irq", A_ESTAT, 32'h0);
        rd("midrst_idle", A_TVAL, 32'h0);
        chk("midrst_has_int", {63'd0, has_int}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
